mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 12, memory address width (4096 words).
REQ-002 Parameter DW, 16, memory data width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req0, req1  in  1 each  access request; req0 = CPU, req1 = I/O DMA.
REQ-006 we0, we1  in  1 each  1 = write, 0 = read; sampled with req.
REQ-007 addr0, addr1  in  AW each  word address.
REQ-008 wdata0, wdata1  in  DW each  write data.
REQ-009 ack0, ack1  out  1 each  one-cycle completion pulse to the owning requester.
REQ-010 rdata  out  DW  read data, shared by both requesters, valid only while ack of a read is high.
REQ-011 mem_adress  out  AW  memory address port.
REQ-012 mem_read, mem_write  out  1 each  memory command strobes.
REQ-013 mem_indata  out  DW  memory write data.
REQ-014 mem_outdata  in  DW  memory read data, registered by memory on the posedge where mem_read=1.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req=1 at the edge; ACCESS->RESP always; RESP->IDLE always.
REQ-016 On the IDLE->ACCESS edge the winner's addr/we/wdata are latched into registers driving mem_adress/mem_indata, and mem_read=!we or mem_write=we.
REQ-017 mem_read and mem_write are high only in ACCESS, are registered outputs, and are never both 1.
REQ-018 Outside ACCESS, mem_adress and mem_indata hold their last values, and mem_read=mem_write=0.
REQ-019 In RESP, the winner's ack pulses high for exactly one cycle; the loser's ack stays 0.
REQ-020 In RESP, rdata equals mem_outdata for reads; rdata holds its previous value for writes.
REQ-021 Latency is fixed: req sampled at edge N, ack high in cycle N+2; throughput is one access per 3 cycles.
REQ-022 Requesters hold req, we, addr and wdata stable until ack; req still high in the cycle after ack is a new request.
REQ-023 Arbitration is round-robin on last_grant: if both req are high, the requester not granted last wins; if one req is high, it wins.
REQ-024 last_grant updates only on the IDLE->ACCESS edge.
REQ-025 Requests arriving during ACCESS or RESP wait; no request is dropped while it is held.
REQ-026 Same-address back-to-back write then read by either requester returns the newly written data.

Reset
REQ-027 With rst_n=0 at an edge, all of the following take these values:
- state=IDLE
- mem_read=mem_write=0
- ack0=ack1=0
- rdata=0
- mem_adress=0
- mem_indata=0
- last_grant=1, so requester 0 wins the first tie.
REQ-028 Reset mid-operation aborts the transfer with no ack.
- A write whose ACCESS cycle coincides with the reset edge is still performed by the memory.
- The requester reissues the request.
REQ-029 Memory contents are not reset.

Structure
REQ-030 A shared package holds AW, DW and the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
REQ-031 The shared package also holds the requester index constants (CPU=0, DMA=1).
REQ-032 One sub-module rr_arbiter2 (inputs req0, req1, last_grant; output winner) is combinational.
- The FSM and the registers stay in mem_arbiter.

Verification
REQ-033 Bench instantiates mem_arbiter with the existing 4096x16 memory and checks:
- Single write, then single read: req0 writes 16'hBEEF to 12'h010; req0 reads 12'h010. Expected: ack0 in cycle N+2 of each access, and rdata=16'hBEEF on the read ack.
- Simultaneous requests after reset: req0 reads 12'h001 and req1 reads 12'h002 in the same cycle. Expected: requester 0 acks first, requester 1 acks 3 cycles later.
- Persistent contention: both req held high for 4 accesses. Expected: acks alternate 0,1,0,1, and mem_read/mem_write are never both 1.
- Reset during read: rst_n=0 in the ACCESS cycle of a read from 12'hFFF. Expected: no ack; next cycle all outputs equal their REQ-027 values; after reset, a read from 12'hFFF returns the stored value.
- Write/read race: req1 writes 16'h1234 to 12'h800 while req0 reads 12'h800, with last_grant=0 (requester 1 favoured). Expected: requester 1 is served first, and req0 then receives rdata=16'h1234.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: bus widths,
// FSM state encoding and requester indices.
package mem_arbiter_pkg;

    localparam int AW = 12;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester indices; also the encoding of winner / last_grant.
    localparam logic CPU = 1'b0;
    localparam logic DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins,
// otherwise the only active requester wins.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner
);

    // Combinational winner selection.
    always_comb begin
        // NOTE: default assignment first so no path leaves winner unassigned (no latch).
        winner = CPU;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (port 0) and DMA (port 1) onto one single-port memory.
// Each access takes IDLE -> ACCESS -> RESP; ack is a one-cycle pulse in RESP.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = mem_arbiter_pkg::AW,
    parameter int DW = mem_arbiter_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_adress,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_indata,
    input  logic [DW-1:0] mem_outdata
);

    state_t        state;
    logic          winner;
    logic          last_grant;
    logic          cur_id;     // requester owning the access in flight
    logic          cur_rd;     // access in flight is a read
    logic [DW-1:0] rdata_q;    // last read result, held across writes

    rr_arbiter2 u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // Access FSM with registered memory strobes, address/data and acks.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            mem_adress <= '0;
            mem_indata <= '0;
            last_grant <= DMA;
            cur_id     <= CPU;
            cur_rd     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state      <= ACCESS;
                        last_grant <= winner;
                        cur_id     <= winner;
                        if (winner == DMA) begin
                            mem_adress <= addr1;
                            mem_indata <= wdata1;
                            mem_read   <= !we1;
                            mem_write  <= we1;
                            cur_rd     <= !we1;
                        end else begin
                            mem_adress <= addr0;
                            mem_indata <= wdata0;
                            mem_read   <= !we0;
                            mem_write  <= we0;
                            cur_rd     <= !we0;
                        end
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    ack0  <= (cur_id == CPU);
                    ack1  <= (cur_id == DMA);
                end
                RESP: begin
                    state <= IDLE;
                    if (cur_rd) begin
                        rdata_q <= mem_outdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory read data is registered by the memory, so it is forwarded
    // directly during RESP of a read and held afterwards.
    assign rdata = (state == RESP && cur_rd) ? mem_outdata : rdata_q;

endmodule
